// File: rtl/trace_pkg.sv
// Shared trace-path definitions: frame length, packet scheduler states and the
// 16-bit statistics counter type with its saturating increment.
package trace_pkg;

  localparam int TRACE_WORDS_PER_PKT = 8;

  typedef enum logic [2:0] {
    IDLE,
    NEXT,
    REQ,
    CAPT,
    B0,
    B1,
    HOLD
  } sched_state_t;

  typedef logic [15:0] trace_cnt_t;

  function automatic trace_cnt_t cnt_sat_inc(input trace_cnt_t c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/trace_word_ser.sv
// trace_word_ser: captures one 16-bit buffer word and replays it as two registered bytes,
// low byte first, on a valid/ready stream; outputs hold steady while the sink stalls.
module trace_word_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capt,
  input  logic        i_first,
  input  logic [15:0] i_word,
  input  logic        i_rdy,
  output logic [7:0]  o_dat,
  output logic        o_vld,
  output logic        o_first
);

  logic [7:0] r_hw_hi;
  logic [7:0] r_dat;
  logic       r_vld;
  logic       r_first;
  logic       r_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hw_hi <= 8'h00;
      r_dat   <= 8'h00;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_hi    <= 1'b0;
    end else if (i_capt) begin
      r_hw_hi <= i_word[15:8];
      r_dat   <= i_word[7:0];
      r_vld   <= 1'b1;
      r_first <= i_first;
      r_hi    <= 1'b0;
    end else if (r_vld && i_rdy) begin
      if (!r_hi) begin
        r_dat   <= r_hw_hi;
        r_first <= 1'b0;
        r_hi    <= 1'b1;
      end else begin
        // dOut keeps the last byte; only valid drops
        r_vld <= 1'b0;
        r_hi  <= 1'b0;
      end
    end
  end

  assign o_dat   = r_dat;
  assign o_vld   = r_vld;
  assign o_first = r_first;

endmodule

// File: rtl/trace_pkt_sched.sv
// trace_pkt_sched: drains whole frames from the trace buffer onto a byte valid/ready stream,
// dropping frames opened while out of sync; TRACE_PKT_STATS_EN builds the frame/drop counters.
module trace_pkt_sched
  import trace_pkg::*;
#(
  parameter int WORDS       = TRACE_WORDS_PER_PKT,
  parameter bit DROP_UNSYNC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PacketAvail,
  input  logic        sync,
  input  logic [15:0] PacketIn,
  output logic        PacketNext,
  output logic        PacketNextWd,
  output logic [7:0]  dOut,
  output logic        dValid,
  input  logic        dReady,
  output logic        dFirst,
  output logic [15:0] frameCount,
  output logic [15:0] dropCount
);

  localparam int              WCW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0]  WC_LAST = WCW'(WORDS - 1);

  sched_state_t   r_state;
  sched_state_t   w_state_nxt;
  logic [WCW-1:0] r_wc;
  logic           r_keep;
  logic           w_acc;
  logic           w_last;
  logic           w_capt;
  logic           w_first;

  assign w_acc   = dValid && dReady;
  assign w_last  = (r_wc == WC_LAST);
  assign w_capt  = (r_state == CAPT);
  assign w_first = (r_wc == '0);

  always_comb begin
    w_state_nxt  = r_state;
    PacketNext   = 1'b0;
    PacketNextWd = 1'b0;
    case (r_state)
      IDLE: if (PacketAvail) w_state_nxt = NEXT;
      NEXT: begin
        PacketNext  = 1'b1;
        w_state_nxt = r_keep ? REQ : HOLD;
      end
      REQ: begin
        PacketNextWd = 1'b1;
        w_state_nxt  = CAPT;
      end
      CAPT: w_state_nxt = B0;
      B0:   if (w_acc) w_state_nxt = B1;
      B1:   if (w_acc) w_state_nxt = w_last ? HOLD : REQ;
      // HOLD lets PacketAvail catch up with the frame just opened
      HOLD: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wc    <= '0;
      r_keep  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) r_keep <= sync || !DROP_UNSYNC;
      if (r_state == NEXT) r_wc <= '0;
      else if (r_state == B1 && w_acc && !w_last) r_wc <= r_wc + 1'b1;
    end
  end

  trace_word_ser u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_capt  (w_capt),
    .i_first (w_first),
    .i_word  (PacketIn),
    .i_rdy   (dReady),
    .o_dat   (dOut),
    .o_vld   (dValid),
    .o_first (dFirst)
  );

`ifdef TRACE_PKT_STATS_EN
  trace_cnt_t r_frame_cnt;
  trace_cnt_t r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_state == NEXT && !r_keep) r_drop_cnt <= cnt_sat_inc(r_drop_cnt);
      if (r_state == B1 && w_acc && w_last) r_frame_cnt <= cnt_sat_inc(r_frame_cnt);
    end
  end

  assign frameCount = r_frame_cnt;
  assign dropCount  = r_drop_cnt;
`else
  assign frameCount = 16'h0000;
  assign dropCount  = 16'h0000;
`endif

endmodule

// File: tb/tb_trace_pkt_sched.sv
// Bench for trace_pkt_sched: a frame-queue buffer model with one-cycle-stale PacketAvail feeds the
// DUT; accepted bytes, strobes and timing are checked against per-frame expectations.
module tb_trace_pkt_sched;

  localparam int W = 8;
`ifdef TRACE_PKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, PacketAvail, sync, dReady;
  logic [15:0] PacketIn;
  logic        PacketNext, PacketNextWd, dValid, dFirst;
  logic [7:0]  dOut;
  logic [15:0] frameCount, dropCount;

  int n_checks = 0;
  int n_fail   = 0;

  trace_pkt_sched #(.WORDS(W), .DROP_UNSYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .PacketAvail(PacketAvail), .sync(sync), .PacketIn(PacketIn),
    .PacketNext(PacketNext), .PacketNextWd(PacketNextWd), .dOut(dOut), .dValid(dValid),
    .dReady(dReady), .dFirst(dFirst), .frameCount(frameCount), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  // buffer model state
  logic [15:0] pend_q[$];
  int          pend_frames = 0, prev_frames = 0;
  logic [15:0] cur_frame[W];
  int          widx = 0;
  logic [15:0] fetched = 16'h0;
  logic        wd_prev = 1'b0;
  int          rdy_mode = 0, rdy_ph = 0;
  // observation state
  int          cyc = 0, quiet = 0;
  int          n_pn = 0, n_wd = 0, n_viol = 0, n_unstable = 0, n_stall = 0;
  int          rise_cyc = -1, pn_cyc = -1, pn2_cyc = -1, wd_cyc = -1, dv_cyc = -1;
  logic        avail_prev = 1'b0, stalled_prev = 1'b0, prev_first = 1'b0;
  logic [7:0]  prev_dout = 8'h0;
  logic [7:0]  obs_q[$];
  logic        obs_first_q[$];
  int          acc_cyc_q[$];
  // expectations
  logic [7:0]  exp_q[$];
  logic        exp_first_q[$];
  int          exp_frames = 0, exp_drops = 0;

  initial begin
    PacketAvail = 1'b0;
    PacketIn    = 16'h0;
    dReady      = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        1: begin dReady = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
        2: dReady = 1'($urandom_range(0, 1));
        default: dReady = 1'b1;
      endcase
      PacketAvail = (prev_frames != 0);
      PacketIn    = wd_prev ? fetched : 16'($urandom);
      if (PacketAvail && !avail_prev && rise_cyc < 0) rise_cyc = cyc;
      avail_prev = PacketAvail;

      if (dValid && dv_cyc < 0) dv_cyc = cyc;
      if (stalled_prev && (!dValid || dOut !== prev_dout || dFirst !== prev_first)) n_unstable++;
      if (dValid && !dReady) n_stall++;
      if (dValid && dReady) begin
        obs_q.push_back(dOut);
        obs_first_q.push_back(dFirst);
        acc_cyc_q.push_back(cyc);
      end
      if (PacketNext && PacketNextWd) n_viol++;
      if ((PacketNext || PacketNextWd) && dValid) n_viol++;
      stalled_prev = dValid && !dReady;
      prev_dout    = dOut;
      prev_first   = dFirst;

      if (PacketNext) begin
        n_pn++;
        if (pn_cyc < 0) pn_cyc = cyc;
        else if (pn2_cyc < 0) pn2_cyc = cyc;
        if (pend_frames > 0) begin
          for (int i = 0; i < W; i++) cur_frame[i] = pend_q.pop_front();
          pend_frames--;
        end
        widx = 0;
      end
      if (PacketNextWd) begin
        n_wd++;
        if (wd_cyc < 0) wd_cyc = cyc;
        fetched = (widx < W) ? cur_frame[widx] : 16'hDEAD;
        widx++;
      end
      wd_prev     = PacketNextWd;
      prev_frames = pend_frames;
      quiet = (dValid || PacketNext || PacketNextWd || pend_frames != 0) ? 0 : quiet + 1;
    end
  end

  task automatic push_frame(input logic [15:0] f[W], input bit fwd);
    for (int k = 0; k < W; k++) begin
      pend_q.push_back(f[k]);
      if (fwd) begin
        exp_q.push_back(f[k][7:0]);   exp_first_q.push_back(k == 0);
        exp_q.push_back(f[k][15:8]);  exp_first_q.push_back(1'b0);
      end
    end
    pend_frames++;
    quiet = 0;
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_first_q.delete(); acc_cyc_q.delete();
    n_pn = 0; n_wd = 0; n_stall = 0;
    rise_cyc = -1; pn_cyc = -1; pn2_cyc = -1; wd_cyc = -1; dv_cyc = -1;
  endtask

  task automatic clear_all();
    clear_obs();
    exp_q.delete(); exp_first_q.delete();
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while (quiet < 6 && n < 3000) begin @(negedge clk); n++; end
    n_checks++;
    if (quiet < 6) begin n_fail++; $display("FAIL %s_timeout: still busy after %0d cycles", name, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; sync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 7;
    if (dValid !== 1'b0)        begin n_fail++; $display("FAIL rst_dValid: got %b want 0", dValid); end
    if (dFirst !== 1'b0)        begin n_fail++; $display("FAIL rst_dFirst: got %b want 0", dFirst); end
    if (dOut !== 8'h00)         begin n_fail++; $display("FAIL rst_dOut: got %h want 00", dOut); end
    if (PacketNext !== 1'b0)    begin n_fail++; $display("FAIL rst_PacketNext: got %b want 0", PacketNext); end
    if (PacketNextWd !== 1'b0)  begin n_fail++; $display("FAIL rst_PacketNextWd: got %b want 0", PacketNextWd); end
    if (frameCount !== 16'h0)   begin n_fail++; $display("FAIL rst_frameCount: got %0d want 0", frameCount); end
    if (dropCount !== 16'h0)    begin n_fail++; $display("FAIL rst_dropCount: got %0d want 0", dropCount); end
    rst = 1'b0;
    exp_frames = 0; exp_drops = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_frame();
    logic [15:0] f[W];
    for (int k = 0; k < W; k++) f[k] = 16'h1100 + 16'(k) * 16'h2222;
    clear_all(); rdy_mode = 0; sync = 1'b1;
    @(posedge clk); #1;
    push_frame(f, 1'b1);
    wait_quiet("single");
    exp_frames++;
    n_checks++;
    if (obs_q.size() !== 2 * W) begin n_fail++; $display("FAIL single_len: got %0d bytes want %0d", obs_q.size(), 2 * W); end
    else for (int i = 0; i < 2 * W; i++) begin
      n_checks++;
      if (obs_q[i] !== 8'(i * 8'h11) || obs_first_q[i] !== (i == 0)) begin
        n_fail++; $display("FAIL single_byte[%0d]: got %h first=%b want %h first=%b", i, obs_q[i], obs_first_q[i], 8'(i * 8'h11), (i == 0));
      end
    end
    n_checks += 7;
    if (pn_cyc !== rise_cyc + 1) begin n_fail++; $display("FAIL single_pn_lat: got %0d want %0d", pn_cyc - rise_cyc, 1); end
    if (wd_cyc !== rise_cyc + 2) begin n_fail++; $display("FAIL single_wd_lat: got %0d want %0d", wd_cyc - rise_cyc, 2); end
    if (dv_cyc !== rise_cyc + 4) begin n_fail++; $display("FAIL single_dv_lat: got %0d want %0d", dv_cyc - rise_cyc, 4); end
    if (n_pn !== 1)              begin n_fail++; $display("FAIL single_pn_cnt: got %0d want 1", n_pn); end
    if (n_wd !== W)              begin n_fail++; $display("FAIL single_wd_cnt: got %0d want %0d", n_wd, W); end
    if (acc_cyc_q.size() > 0 && acc_cyc_q[$] - pn_cyc !== 4 * W) begin
      n_fail++; $display("FAIL single_frame_len: got %0d want %0d", acc_cyc_q[$] - pn_cyc, 4 * W);
    end
    if (frameCount !== (STATS ? 16'(exp_frames) : 16'h0)) begin
      n_fail++; $display("FAIL single_frameCount: got %0d want %0d", frameCount, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_stall();
    logic [15:0] f[W];
    for (int k = 0; k < W; k++) f[k] = 16'h1100 + 16'(k) * 16'h2222;
    clear_all(); rdy_mode = 1; rdy_ph = 0; sync = 1'b1;
    @(posedge clk); #1;
    push_frame(f, 1'b1);
    wait_quiet("stall");
    rdy_mode = 0;
    exp_frames++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_first_q[i] !== exp_first_q[i]) begin
        n_fail++; $display("FAIL stall_byte[%0d]: got %h first=%b want %h first=%b", i, obs_q[i], obs_first_q[i], exp_q[i], exp_first_q[i]);
      end
    end
    n_checks += 4;
    if (n_stall == 0)     begin n_fail++; $display("FAIL stall_none: got %0d stall cycles want >0", n_stall); end
    if (n_unstable !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", n_unstable); end
    if (n_wd !== W)       begin n_fail++; $display("FAIL stall_wd_cnt: got %0d want %0d", n_wd, W); end
    if (acc_cyc_q.size() > 0 && acc_cyc_q[$] - pn_cyc !== 4 * W + n_stall) begin
      n_fail++; $display("FAIL stall_frame_len: got %0d want %0d", acc_cyc_q[$] - pn_cyc, 4 * W + n_stall);
    end
  endtask

  task automatic test_drop();
    logic [15:0] f[W];
    for (int k = 0; k < W; k++) f[k] = 16'($urandom);
    clear_all(); sync = 1'b0;
    @(posedge clk); #1;
    push_frame(f, 1'b0);
    wait_quiet("drop");
    exp_drops++;
    n_checks += 5;
    if (n_pn !== 1)          begin n_fail++; $display("FAIL drop_pn_cnt: got %0d want 1", n_pn); end
    if (n_wd !== 0)          begin n_fail++; $display("FAIL drop_wd_cnt: got %0d want 0", n_wd); end
    if (dv_cyc !== -1)       begin n_fail++; $display("FAIL drop_dValid: got valid at cycle %0d want none", dv_cyc); end
    if (obs_q.size() !== 0)  begin n_fail++; $display("FAIL drop_bytes: got %0d want 0", obs_q.size()); end
    if (dropCount !== (STATS ? 16'(exp_drops) : 16'h0)) begin
      n_fail++; $display("FAIL drop_dropCount: got %0d want %0d", dropCount, STATS ? exp_drops : 0);
    end
    sync = 1'b1;
  endtask

  task automatic test_sync_midframe();
    logic [15:0] f[W];
    int n = 0;
    for (int k = 0; k < W; k++) f[k] = 16'($urandom);
    clear_all(); sync = 1'b1;
    @(posedge clk); #1;
    push_frame(f, 1'b1);
    while (pn_cyc < 0 && n < 50) begin @(negedge clk); n++; end
    sync = 1'b0;
    wait_quiet("midsync");
    sync = 1'b1;
    exp_frames++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midsync_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midsync_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f[W];
    clear_all(); rdy_mode = 0; sync = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < W; k++) f[k] = 16'($urandom);
      push_frame(f, 1'b1);
    end
    wait_quiet("b2b");
    exp_frames += 2;
    n_checks++;
    if (obs_q.size() !== 4 * W) begin n_fail++; $display("FAIL b2b_len: got %0d bytes want %0d", obs_q.size(), 4 * W); end
    else begin
      for (int i = 0; i < 4 * W; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_first_q[i] !== exp_first_q[i]) begin
          n_fail++; $display("FAIL b2b_byte[%0d]: got %h first=%b want %h first=%b", i, obs_q[i], obs_first_q[i], exp_q[i], exp_first_q[i]);
        end
      end
      // last accept, then HOLD and IDLE, then the next strobe
      n_checks++;
      if (pn2_cyc - acc_cyc_q[2 * W - 1] !== 3) begin
        n_fail++; $display("FAIL b2b_gap: got %0d want 3", pn2_cyc - acc_cyc_q[2 * W - 1]);
      end
    end
    n_checks += 2;
    if (n_pn !== 2) begin n_fail++; $display("FAIL b2b_pn_cnt: got %0d want 2", n_pn); end
    if (frameCount !== (STATS ? 16'(exp_frames) : 16'h0)) begin
      n_fail++; $display("FAIL b2b_frameCount: got %0d want %0d", frameCount, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] f[W];
    int n = 0;
    clear_all(); rdy_mode = 0; sync = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < W; k++) f[k] = 16'($urandom);
    push_frame(f, 1'b0);
    for (int k = 0; k < W; k++) f[k] = 16'($urandom);
    push_frame(f, 1'b1);
    do begin @(posedge clk); #1; n++; end while (!(dValid && obs_q.size() == 7) && n < 300);
    n_checks++;
    if (frameCount !== (STATS ? 16'(exp_frames) : 16'h0)) begin
      n_fail++; $display("FAIL rstmid_pre_frameCount: got %0d want %0d", frameCount, STATS ? exp_frames : 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks += 5;
    if (dValid !== 1'b0)       begin n_fail++; $display("FAIL rstmid_dValid: got %b want 0", dValid); end
    if (PacketNext !== 1'b0)   begin n_fail++; $display("FAIL rstmid_PacketNext: got %b want 0", PacketNext); end
    if (PacketNextWd !== 1'b0) begin n_fail++; $display("FAIL rstmid_PacketNextWd: got %b want 0", PacketNextWd); end
    if (frameCount !== 16'h0)  begin n_fail++; $display("FAIL rstmid_frameCount: got %0d want 0", frameCount); end
    if (dropCount !== 16'h0)   begin n_fail++; $display("FAIL rstmid_dropCount: got %0d want 0", dropCount); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_frames = 0; exp_drops = 0;
    clear_obs();
    wait_quiet("rstmid");
    exp_frames++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_len: got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_first_q[i] !== exp_first_q[i]) begin
        n_fail++; $display("FAIL rstmid_byte[%0d]: got %h first=%b want %h first=%b", i, obs_q[i], obs_first_q[i], exp_q[i], exp_first_q[i]);
      end
    end
    n_checks++;
    if (frameCount !== (STATS ? 16'(exp_frames) : 16'h0)) begin
      n_fail++; $display("FAIL rstmid_frameCount: got %0d want %0d", frameCount, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] f[W];
    bit s;
    rdy_mode = 2;
    for (int it = 0; it < 6; it++) begin
      s = (it % 3 != 1);
      for (int k = 0; k < W; k++) f[k] = 16'($urandom);
      clear_all();
      sync = s;
      @(posedge clk); #1;
      push_frame(f, s);
      wait_quiet("rand");
      if (s) exp_frames++; else exp_drops++;
      n_checks += 2;
      if (n_wd !== (s ? W : 0)) begin n_fail++; $display("FAIL rand_wd_cnt[%0d]: got %0d want %0d", it, n_wd, s ? W : 0); end
      if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_len[%0d]: got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_first_q[i] !== exp_first_q[i]) begin
          n_fail++; $display("FAIL rand_byte[%0d][%0d]: got %h first=%b want %h first=%b", it, i, obs_q[i], obs_first_q[i], exp_q[i], exp_first_q[i]);
        end
      end
    end
    rdy_mode = 0; sync = 1'b1;
    n_checks += 4;
    if (n_unstable !== 0) begin n_fail++; $display("FAIL rand_stable: got %0d changes want 0", n_unstable); end
    if (n_viol !== 0)     begin n_fail++; $display("FAIL rand_strobe_rules: got %0d violations want 0", n_viol); end
    if (frameCount !== (STATS ? 16'(exp_frames) : 16'h0)) begin
      n_fail++; $display("FAIL rand_frameCount: got %0d want %0d", frameCount, STATS ? exp_frames : 0);
    end
    if (dropCount !== (STATS ? 16'(exp_drops) : 16'h0)) begin
      n_fail++; $display("FAIL rand_dropCount: got %0d want %0d", dropCount, STATS ? exp_drops : 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_drop();
    test_sync_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
